// File: rtl/move_arbiter.sv
// move_arbiter: two-player turn arbiter that turns command handshakes
// into timed move pulses and keeps game and match tallies.
//
// Ports
//   clk, rst              clock, async active-low reset
//   a_valid/a_cmd/a_ready player A command handshake
//   b_valid/b_cmd/b_ready player B command handshake
//                         cmd: 00 left, 01 right, 10 put, 11 reserved
//   player                0 = A's turn, 1 = B's turn
//   win_a, win_b,
//   full_panel,
//   invalid_move          game status from the datapath
//   left, right, put      move lines (datapath acts on falling edge)
//   game_rst              active-high game reset
//   new_game, match_clear operator level requests
//   wins_a, wins_b, draws saturating match tallies
//   match_over            a player reached MATCH_WINS
//   rejected              one-cycle strobe for a refused command
module move_arbiter #(
    parameter int PULSE_W    = 2,
    parameter int GAP_W      = 6,
    parameter int RST_W      = 2,
    parameter int MATCH_WINS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_valid,
    input  logic [1:0] a_cmd,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [1:0] b_cmd,
    output logic       b_ready,
    input  logic       player,
    input  logic       win_a,
    input  logic       win_b,
    input  logic       full_panel,
    input  logic       invalid_move,
    output logic       left,
    output logic       right,
    output logic       put,
    output logic       game_rst,
    input  logic       new_game,
    input  logic       match_clear,
    output logic [3:0] wins_a,
    output logic [3:0] wins_b,
    output logic [3:0] draws,
    output logic       match_over,
    output logic       rejected
);

    typedef enum logic [2:0] {
        GRST, SETTLE, IDLE, PULSE,
        GAP, GAME_OVER, MATCH_OVER
    } state_t;

    localparam logic [1:0] CMD_L = 2'b00;
    localparam logic [1:0] CMD_R = 2'b01;
    localparam logic [1:0] CMD_P = 2'b10;
    localparam logic [1:0] CMD_X = 2'b11;
    localparam logic [3:0] MW    = 4'(MATCH_WINS);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] cmd_q, cmd_d;
    logic       inv_q, inv_d;
    logic       rej_q, rej_d;
    logic [3:0] wa_q, wa_d;
    logic [3:0] wb_q, wb_d;
    logic [3:0] dr_q, dr_d;

    logic       a_xfer, b_xfer, xfer;
    logic [1:0] xcmd;
    logic       last;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Ready follows the turn, so both-valid contention resolves itself.
    assign a_ready = (state_q == IDLE) & ~player;
    assign b_ready = (state_q == IDLE) & player;
    assign a_xfer  = a_valid & a_ready;
    assign b_xfer  = b_valid & b_ready;
    assign xfer    = a_xfer | b_xfer;
    assign xcmd    = a_xfer ? a_cmd : b_cmd;
    assign last    = (cnt_q == 8'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
        cmd_d   = cmd_q;
        inv_d   = inv_q;
        rej_d   = 1'b0;
        wa_d    = wa_q;
        wb_d    = wb_q;
        dr_d    = dr_q;
        unique case (state_q)
            GRST: begin
                if (last) begin
                    state_d = SETTLE;
                    cnt_d   = 8'd2;
                end
            end
            SETTLE: begin
                if (last) state_d = IDLE;
            end
            IDLE: begin
                if (xfer) begin
                    cmd_d = xcmd;
                    if (xcmd == CMD_X) begin
                        rej_d = 1'b1;
                    end else begin
                        state_d = PULSE;
                        cnt_d   = 8'(PULSE_W);
                    end
                end
            end
            PULSE: begin
                if (last) begin
                    state_d = GAP;
                    cnt_d   = 8'(GAP_W);
                    inv_d   = 1'b0;
                end
            end
            GAP: begin
                // inv_q limits the refusal strobe to one per put.
                if (cmd_q == CMD_P && invalid_move && !inv_q) begin
                    rej_d = 1'b1;
                    inv_d = 1'b1;
                end
                if (last) begin
                    state_d = IDLE;
                    if (cmd_q == CMD_P) begin
                        if (win_a) begin
                            wa_d    = sat_inc(wa_q);
                            state_d = GAME_OVER;
                        end else if (win_b) begin
                            wb_d    = sat_inc(wb_q);
                            state_d = GAME_OVER;
                        end else if (full_panel) begin
                            dr_d    = sat_inc(dr_q);
                            state_d = GAME_OVER;
                        end
                    end
                end
            end
            GAME_OVER: begin
                if (match_clear) begin
                    wa_d    = 4'd0;
                    wb_d    = 4'd0;
                    dr_d    = 4'd0;
                    state_d = GRST;
                    cnt_d   = 8'(RST_W);
                end else if (wa_q == MW || wb_q == MW) begin
                    state_d = MATCH_OVER;
                end else if (new_game) begin
                    state_d = GRST;
                    cnt_d   = 8'(RST_W);
                end
            end
            MATCH_OVER: begin
                if (match_clear) begin
                    wa_d    = 4'd0;
                    wb_d    = 4'd0;
                    dr_d    = 4'd0;
                    state_d = GRST;
                    cnt_d   = 8'(RST_W);
                end
            end
            default: begin
                state_d = GRST;
                cnt_d   = 8'(RST_W);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= GRST;
            cnt_q   <= 8'(RST_W);
            cmd_q   <= CMD_L;
            inv_q   <= 1'b0;
            rej_q   <= 1'b0;
            wa_q    <= 4'd0;
            wb_q    <= 4'd0;
            dr_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            inv_q   <= inv_d;
            rej_q   <= rej_d;
            wa_q    <= wa_d;
            wb_q    <= wb_d;
            dr_q    <= dr_d;
        end
    end

    // Decoded from state so reset drops the lines asynchronously.
    assign left       = (state_q == PULSE) & (cmd_q == CMD_L);
    assign right      = (state_q == PULSE) & (cmd_q == CMD_R);
    assign put        = (state_q == PULSE) & (cmd_q == CMD_P);
    assign game_rst   = (state_q == GRST);
    assign match_over = (state_q == MATCH_OVER);
    assign rejected   = rej_q;
    assign wins_a     = wa_q;
    assign wins_b     = wb_q;
    assign draws      = dr_q;

endmodule

// File: tb/tb_move_arbiter.sv
// tb_move_arbiter: randomized scoreboard bench for move_arbiter.
// Expected move/refusal events are queued by stimulus, popped by a monitor.
module tb_move_arbiter;

    localparam int PULSE_W    = 2;
    localparam int GAP_W      = 6;
    localparam int RST_W      = 2;
    localparam int MATCH_WINS = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, b_valid, a_ready, b_ready;
    logic [1:0] a_cmd, b_cmd;
    logic       player, win_a, win_b, full_panel, invalid_move;
    logic       left, right, put, game_rst;
    logic       new_game, match_clear, match_over, rejected;
    logic [3:0] wins_a, wins_b, draws;

    move_arbiter #(
        .PULSE_W(PULSE_W), .GAP_W(GAP_W),
        .RST_W(RST_W), .MATCH_WINS(MATCH_WINS)
    ) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_cmd(a_cmd), .a_ready(a_ready),
        .b_valid(b_valid), .b_cmd(b_cmd), .b_ready(b_ready),
        .player(player), .win_a(win_a), .win_b(win_b),
        .full_panel(full_panel), .invalid_move(invalid_move),
        .left(left), .right(right), .put(put),
        .game_rst(game_rst),
        .new_game(new_game), .match_clear(match_clear),
        .wins_a(wins_a), .wins_b(wins_b), .draws(draws),
        .match_over(match_over), .rejected(rejected)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    // Event codes: 0 left, 1 right, 2 put, 3 rejected.
    int exp_q[$];
    int m_a = 0, m_b = 0, m_d = 0;
    bit allow_clear = 1'b1;
    bit match_seen = 1'b0;
    bit got;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int inc15(input int v);
        return (v < 15) ? v + 1 : 15;
    endfunction

    task automatic chk_tallies();
        chk("wins_a", 32'(wins_a), m_a);
        chk("wins_b", 32'(wins_b), m_b);
        chk("draws", 32'(draws), m_d);
    endtask

    task automatic pop_cmp(input int code);
        int e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event", code, 99);
        end else begin
            e = exp_q.pop_front();
            chk("event", code, e);
        end
    endtask

    // Monitor: pulse starts and refusal strobes against the queue.
    logic [2:0] prev_l = 3'b0;
    int width = 0;
    int gapc = 0;
    always @(negedge clk) begin
        logic [2:0] cur;
        int code;
        if (!rst) begin
            prev_l = 3'b0;
            width = 0;
            gapc = 0;
        end else begin
            cur = {left, right, put};
            if (cur != 3'b0 && prev_l == 3'b0) begin
                case (cur)
                    3'b100:  code = 0;
                    3'b010:  code = 1;
                    3'b001:  code = 2;
                    default: code = 7;
                endcase
                chk("gap_before_pulse", gapc, 0);
                pop_cmp(code);
                width = 1;
            end else if (cur != 3'b0) begin
                width++;
            end else if (prev_l != 3'b0) begin
                chk("pulse_width", width, PULSE_W);
                gapc = GAP_W - 1;
            end else if (gapc > 0) begin
                gapc--;
            end
            if (rejected) pop_cmp(3);
            prev_l = cur;
        end
    end

    // Call just after the edge that enters GRST.
    task automatic restart_chk();
        int ngr = 0;
        int nrdy = 0;
        for (int i = 0; i < RST_W + 2; i++) begin
            @(negedge clk);
            ngr += int'(game_rst);
            nrdy += int'(a_ready | b_ready);
        end
        chk("grst_cycles", ngr, RST_W);
        chk("settle_no_ready", nrdy, 0);
        @(negedge clk);
        chk("idle_ready", a_ready | b_ready, 1);
    endtask

    task automatic game_over();
        int p;
        @(negedge clk);
        chk_tallies();
        chk("gameover_ready", a_ready | b_ready, 0);
        chk("gameover_grst", game_rst, 0);
        if (m_a == MATCH_WINS || m_b == MATCH_WINS) begin
            match_seen = 1'b1;
            @(posedge clk); #1;
            new_game = 1'b1;
            repeat (3) begin
                @(negedge clk);
                chk("match_over", match_over, 1);
                chk("match_ignores_new", game_rst, 0);
            end
            @(posedge clk); #1;
            match_clear = 1'b1;
            @(posedge clk); #1;
            match_clear = 1'b0;
            new_game = 1'b0;
            m_a = 0; m_b = 0; m_d = 0;
            chk("match_cleared", match_over, 0);
            restart_chk();
            chk_tallies();
        end else begin
            chk("no_match", match_over, 0);
            p = allow_clear ? $urandom_range(0, 3) : 1;
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                chk("wait_new_game", game_rst, 0);
            end
            @(posedge clk); #1;
            if (p == 0) begin
                match_clear = 1'b1;
                new_game = 1'($urandom_range(0, 1));
                m_a = 0; m_b = 0; m_d = 0;
            end else begin
                new_game = 1'b1;
            end
            @(posedge clk); #1;
            match_clear = 1'b0;
            new_game = 1'b0;
            restart_chk();
            chk_tallies();
        end
    endtask

    // st = {win_a, win_b, full_panel} shown on the last GAP cycle.
    task automatic issue(input bit side, input logic [1:0] cmd,
                         input bit inv, input logic [2:0] st,
                         input bit offturn, input bit both,
                         input bit noise);
        bit ok;
        int k;
        @(posedge clk); #1;
        exp_q.push_back(int'(cmd));
        if (cmd == 2'b10 && inv) exp_q.push_back(3);
        player = offturn ? ~side : side;
        if (side) begin
            b_valid = 1'b1; b_cmd = cmd;
        end else begin
            a_valid = 1'b1; a_cmd = cmd;
        end
        if (offturn) begin
            repeat ($urandom_range(1, 4)) begin
                @(negedge clk);
                chk("offturn_ready", side ? b_ready : a_ready, 0);
            end
            @(posedge clk); #1;
            player = side;
        end else if (both) begin
            if (side) begin
                a_valid = 1'b1; a_cmd = 2'($urandom);
            end else begin
                b_valid = 1'b1; b_cmd = 2'($urandom);
            end
        end
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = side ? b_ready : a_ready;
        end
        chk("handshake", ok, 1);
        @(posedge clk); #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        match_clear = noise;
        if (cmd == 2'b11) begin
            repeat (2) @(posedge clk);
            #1;
            match_clear = 1'b0;
            chk("reserved_idle", side ? b_ready : a_ready, 1);
            chk_tallies();
        end else begin
            repeat (PULSE_W) @(posedge clk);
            k = $urandom_range(0, GAP_W - 1);
            for (int j = 0; j < GAP_W; j++) begin
                #1;
                chk("busy_ready", a_ready | b_ready, 0);
                invalid_move = inv && (j >= k);
                if (j == GAP_W - 1) {win_a, win_b, full_panel} = st;
                @(posedge clk);
            end
            #1;
            {win_a, win_b, full_panel} = 3'b0;
            invalid_move = 1'b0;
            match_clear = 1'b0;
            if (cmd == 2'b10 && st != 3'b0) begin
                if (st[2]) m_a = inc15(m_a);
                else if (st[1]) m_b = inc15(m_b);
                else m_d = inc15(m_d);
                game_over();
            end else begin
                chk("back_to_idle", side ? b_ready : a_ready, 1);
                chk_tallies();
            end
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [1:0] c;
        logic [2:0] s;
        bit off;
        rst = 1'b0;
        a_valid = 0; b_valid = 0; a_cmd = 0; b_cmd = 0;
        player = 0; win_a = 0; win_b = 0; full_panel = 0;
        invalid_move = 0; new_game = 0; match_clear = 0;

        repeat (2) @(negedge clk);
        chk("rst_game_rst", game_rst, 1);
        chk("rst_lines", {left, right, put}, 0);
        chk("rst_ready", {a_ready, b_ready}, 0);
        chk("rst_rejected", rejected, 0);
        chk("rst_match_over", match_over, 0);
        chk_tallies();

        @(posedge clk); #1;
        rst = 1'b1;
        restart_chk();
        chk("a_ready_first", a_ready, 1);
        chk("b_ready_first", b_ready, 0);

        issue(0, 2'b10, 0, 3'b000, 0, 0, 0);
        issue(1, 2'b01, 0, 3'b000, 1, 0, 0);
        issue(0, 2'b10, 0, 3'b010, 0, 0, 0);
        issue(1, 2'b11, 0, 3'b000, 0, 0, 0);
        issue(0, 2'b10, 1, 3'b000, 0, 0, 0);
        issue(1, 2'b00, 1, 3'b111, 0, 1, 1);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 6);
            c = (r < 4) ? 2'(r) : 2'b10;
            s = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 7)) : 3'b0;
            off = 1'($urandom_range(0, 1));
            issue(1'($urandom_range(0, 1)), c,
                  ($urandom_range(0, 3) == 0), s, off,
                  !off && ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 1) == 1));
        end

        allow_clear = 1'b0;
        match_seen = 1'b0;
        for (int n = 0; n < 20 && !match_seen; n++)
            issue(1'($urandom_range(0, 1)), 2'b10, 0, 3'b100, 0, 0, 0);
        chk("match_reached", match_seen, 1);

        for (int n = 0; n < 17; n++)
            issue(1'($urandom_range(0, 1)), 2'b10, 0, 3'b001, 0, 0, 0);
        chk("draws_saturated", 32'(draws), 15);

        @(posedge clk); #1;
        player = 0; a_valid = 1'b1; a_cmd = 2'b10;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = a_ready;
        end
        chk("rst_test_handshake", got, 1);
        @(posedge clk); #1;
        a_valid = 1'b0;
        chk("put_before_rst", put, 1);
        #1 rst = 1'b0;
        #1;
        m_a = 0; m_b = 0; m_d = 0;
        chk("put_async_drop", put, 0);
        chk("grst_async", game_rst, 1);
        chk_tallies();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        restart_chk();
        chk_tallies();

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
